// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack, normalise/round, pack) with valid/ready flow.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int XW     = EXP_W + 2;
    localparam int PW     = 2*MAN_W + 2;
    localparam int STAGES = 3;
`ifdef FP_MUL_RNE_EN
    localparam int PKW = PW;
`else
    // Truncation never looks below the kept fraction, so the low product bits are not carried
    localparam int PKW = MAN_W + 2;
`endif
    localparam int DROP = PW - PKW;

    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X = '0;
    localparam logic signed [XW-1:0] EMAX_X = XW'(2**EXP_W - 1);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic                 sign;
        logic                 nan;
        logic                 inf;
        logic                 zero;
        logic signed [XW-1:0] exp;
        logic [PKW-1:0]       prod;
    } s1_t;

    typedef struct packed {
        logic                 sign;
        logic                 nan;
        logic                 inf;
        logic                 zero;
        logic signed [XW-1:0] exp;
        logic [MAN_W-1:0]     frac;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            adv;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic [W-1:0]    out_d;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // S1: classify operands, multiply significands, add exponents
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea     = a[W-2 -: EXP_W];
    assign eb     = b[W-2 -: EXP_W];
    assign fa     = a[MAN_W-1:0];
    assign fb     = b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & (fa == '0);
    assign b_inf  = (&eb) & (fb == '0);
    assign a_nan  = (&ea) & (fa != '0);
    assign b_nan  = (&eb) & (fb != '0);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = a[W-1] ^ b[W-1];
        s1_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s1_d.inf  = a_inf | b_inf;
        s1_d.zero = a_zero | b_zero;
        s1_d.exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
        s1_d.prod = PKW'((PW'({1'b1, fa}) * PW'({1'b1, fb})) >> DROP);
    end

    // S2: normalise by the product MSB, then round
    logic                 msb;
    logic [MAN_W-1:0]     frac_t;
    logic signed [XW-1:0] exp_n;

    assign msb    = s1_q.prod[PKW-1];
    assign frac_t = msb ? s1_q.prod[PKW-2 -: MAN_W] : s1_q.prod[PKW-3 -: MAN_W];
    assign exp_n  = s1_q.exp + (msb ? ONE_X : ZERO_X);

`ifdef FP_MUL_RNE_EN
    logic             guard, sticky, carry;
    logic [MAN_W-1:0] frac_r;

    assign guard  = msb ? s1_q.prod[PKW-2-MAN_W] : s1_q.prod[PKW-3-MAN_W];
    assign sticky = (|s1_q.prod[PKW-4-MAN_W:0]) | (msb & s1_q.prod[PKW-3-MAN_W]);
    // An all-ones fraction rounding up wraps to zero; the carry bumps the exponent
    assign {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, guard & (sticky | frac_t[0])};
`endif

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        s2_d.zero = s1_q.zero;
`ifdef FP_MUL_RNE_EN
        s2_d.frac = frac_r;
        s2_d.exp  = exp_n + (carry ? ONE_X : ZERO_X);
`else
        s2_d.frac = frac_t;
        s2_d.exp  = exp_n;
`endif
    end

    // S3: special values override the packed result in priority order
    always_comb begin
        out_d = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.frac};
        if (s2_q.nan)
            out_d = QNAN;
        else if (s2_q.inf || s2_q.exp >= EMAX_X)
            out_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (s2_q.zero || s2_q.exp <= ZERO_X)
            out_d = {s2_q.sign, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            out      <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid)    s1_q <= s1_d;
            if (vld_pipe[1]) s2_q <= s2_d;
            if (vld_pipe[2]) out  <= out_d;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised bench for fp_mul_pipe: bfloat16 instance against a value-level reference model,
// plus an FP32 instance; covers specials, rounding, backpressure and mid-flight reset.
module tb_fp_mul_pipe;
`ifdef FP_MUL_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [15:0] a = 0, b = 0, out;
    logic        in_valid32 = 0, in_ready32, out_valid32, out_ready32 = 1;
    logic [31:0] a32 = 0, b32 = 0, out32;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out));

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out(out32));

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value-level model: exact integer product, remainder compared against one half ulp
    function automatic longint unsigned ref_mul(input int E, input int M,
                                                input longint unsigned x, input longint unsigned y);
        longint unsigned emask = (64'd1 << E) - 1, fmask = (64'd1 << M) - 1;
        longint unsigned fx = x & fmask, fy = y & fmask, p, q, rem, half;
        longint ex = longint'((x >> M) & emask), ey = longint'((y >> M) & emask), e;
        longint unsigned s = ((x >> (E+M)) ^ (y >> (E+M))) & 1;
        bit xz = (ex == 0), yz = (ey == 0);
        bit xi = (ex == longint'(emask)) && fx == 0, yi = (ey == longint'(emask)) && fy == 0;
        bit xn = (ex == longint'(emask)) && fx != 0, yn = (ey == longint'(emask)) && fy != 0;
        int sh = M;
        if (xn || yn || (xi && yz) || (yi && xz)) return (emask << M) | (64'd1 << (M-1));
        if (xi || yi) return (s << (E+M)) | (emask << M);
        if (xz || yz) return s << (E+M);
        p = (fx | (64'd1 << M)) * (fy | (64'd1 << M));
        e = ex + ey - ((64'sd1 <<< (E-1)) - 1);
        if ((p >> (2*M+1)) != 0) begin sh = M + 1; e++; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh-1);
        if (RNE && (rem > half || (rem == half && q[0]))) q++;
        if ((q >> (M+1)) != 0) begin q = q >> 1; e++; end
        if (e >= longint'(emask)) return (s << (E+M)) | (emask << M);
        if (e <= 0) return s << (E+M);
        return (s << (E+M)) | (longint'(e) << M) | (q & fmask);
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] v = 16'($urandom);
        if ($urandom_range(1, 0) == 1) v[14:7] = 8'($urandom_range(135, 119));
        return v;
    endfunction

    typedef struct { logic [15:0] val; int acc; } exp_t;
    exp_t        sbq[$];
    int          cyc = 0, last_stall = -1;
    bit          hold_pend = 0;
    logic [15:0] held;

    // One cycle: drive at negedge, observe the handshakes that the next posedge will perform
    task automatic step(input bit iv, input logic [15:0] av, input logic [15:0] bv, input bit ordy,
                        input bit use_ev, input logic [15:0] ev, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv; a = av; b = bv; out_ready = ordy;
        #1;
        cyc++;
        if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_out", out, held);
        end
        hold_pend = 0;
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            held = out; hold_pend = 1; last_stall = cyc;
        end
        if (out_valid && out_ready) begin
            chk("sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("result", out, e.val);
                if (e.acc > last_stall) chk("latency", cyc - e.acc, 3);
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e.val = use_ev ? ev : 16'(ref_mul(8, 7, av, bv));
            e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        bit dummy;
        for (int i = 0; i < 30 && sbq.size() > 0; i++) step(0, 0, 0, 1, 0, 0, dummy);
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic fp32_op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev);
        @(negedge clk); in_valid32 = 1; a32 = av; b32 = bv;
        @(negedge clk); in_valid32 = 0;
        @(negedge clk); chk("fp32_early", out_valid32, 0);
        @(negedge clk); #1;
        chk("fp32_valid", out_valid32, 1);
        chk("fp32_out", out32, ev);
    endtask

    logic [15:0] dir_a[11] = '{16'h3FC0, 16'h3FC0, 16'h3F81, 16'h3F81, 16'h7F00, 16'h7F80,
                               16'h8000, 16'h0080, 16'h0001, 16'h7FC1, 16'hFF80};
    logic [15:0] dir_b[11] = '{16'h4000, 16'h3FC0, 16'h3FC0, 16'h3F81, 16'h4000, 16'h0000,
                               16'h3F80, 16'h0080, 16'h3F80, 16'h3F80, 16'h4000};
    logic [15:0] dir_e[11] = '{16'h4040, 16'h4010, RNE ? 16'h3FC2 : 16'h3FC1, 16'h3F82, 16'h7F80,
                               16'h7FC0, 16'h8000, 16'h0000, 16'h0000, 16'h7FC0, 16'hFF80};

    initial begin
        bit          acc;
        int          tries, p;
        logic [15:0] av, bv;
        logic [31:0] ra, rb;

        @(negedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst = 0;

        // Directed values back to back, no backpressure
        for (int i = 0; i < 11; i++) begin
            step(1, dir_a[i], dir_b[i], 1, 1, dir_e[i], acc);
            chk("dir_accept", acc, 1);
        end
        drain();

        // Random operands with bubbles and random backpressure
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3, 0) == 0) step(0, 0, 0, $urandom_range(9, 0) < 7, 0, 0, acc);
            av = rnd16(); bv = rnd16(); tries = 0;
            do begin
                step(1, av, bv, $urandom_range(9, 0) < 7, 0, 0, acc);
                tries++;
            end while (!acc && tries < 50);
            chk("rnd_accept", acc, 1);
        end
        drain();

        // Eight back-to-back pairs with out_ready cycling 1,0,0
        p = 0;
        for (int i = 0; i < 8; i++) begin
            av = rnd16(); bv = rnd16(); tries = 0;
            do begin
                step(1, av, bv, (p % 3) == 0, 0, 0, acc);
                p++; tries++;
            end while (!acc && tries < 50);
            chk("bp_accept", acc, 1);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, (p % 3) == 0, 0, 0, acc);
            p++;
        end
        drain();

        // Reset while three products are in flight
        for (int i = 0; i < 3; i++) step(1, 16'h3FC0, 16'h4000, 1, 0, 0, acc);
        @(negedge clk);
        in_valid = 0; rst = 1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        sbq.delete();
        hold_pend = 0;
        @(negedge clk); rst = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 0, 0, acc);
            chk("postrst_idle", out_valid, 0);
        end
        step(1, 16'h3FC0, 16'h3FC0, 1, 1, 16'h4010, acc);
        chk("postrst_accept", acc, 1);
        drain();

        // FP32 instance
        fp32_op(32'h3FC00000, 32'h40000000, 32'h40400000);
        fp32_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            ra[30:23] = 8'($urandom_range(140, 115));
            rb[30:23] = 8'($urandom_range(140, 115));
            fp32_op(ra, rb, 32'(ref_mul(8, 23, ra, rb)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
